cpu2_seq: RTL and testbench

Multi-cycle fetch/execute sequencer for the cpu2 core, upstream of the register file. Fetches instructions from memory at the register-file PC and decodes them. Drives the register-file address selects and function strobes: PC increment, link, writeback and post-increment. Performs load/store memory handshakes and selects writeback data between the ALU result and memory read data.

---
 rtl/cpu2_seq_pkg.sv | 38 +++
 rtl/cpu2_seq_dec.sv | 67 ++++++
 rtl/cpu2_seq.sv | 143 ++++++++++++++
 tb/tb_cpu2_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu2_seq_pkg.sv
// cpu2_seq shared definitions: opcodes, FSM states, instruction field positions.
package cpu2_seq_pkg;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_ST   = 4'h2;
  localparam logic [3:0] OP_CALL = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 28;
  localparam int D_LO    = 24;
  localparam int A_LO    = 20;
  localparam int B_LO    = 16;
  localparam int PINC_B  = 16;
  localparam int IMM_W   = 16;
  localparam logic [3:0] R_PC = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  function automatic state_t fetch_next(
    input logic [3:0] op
  );
    state_t s;
    s = S_EXEC;
    if (op == OP_LD || op == OP_ST)
      s = S_MEM;
    else if (op == OP_HALT)
      s = S_HALT;
    return s;
  endfunction

endpackage

// File: rtl/cpu2_seq_dec.sv
// cpu2_seq instruction decode: register selects and class flags.
// Post-increment honoured only with CPU2_SEQ_POSTINC_EN defined.
module cpu2_seq_dec
  import cpu2_seq_pkg::*;
(
  input  logic [31:0]      i_ir,
  output logic [3:0]       o_ra,
  output logic [3:0]       o_rb,
  output logic [3:0]       o_rd,
  output logic [3:0]       o_rw,
  output logic [3:0]       o_rt,
  output logic [3:0]       o_alu_op,
  output logic [IMM_W-1:0] o_imm,
  output logic             o_is_mem,
  output logic             o_is_st,
  output logic             o_is_wb,
  output logic             o_is_link,
  output logic             o_pinc
);

  logic [3:0] w_op;
  logic [3:0] w_d;
  logic [3:0] w_a;

  assign w_op = i_ir[OP_HI:OP_LO];
  assign w_d  = i_ir[D_LO+3:D_LO];
  assign w_a  = i_ir[A_LO+3:A_LO];

  always_comb begin
    o_ra      = w_a;
    o_rb      = i_ir[B_LO+3:B_LO];
    o_rd      = w_d;
    o_rt      = w_d;
    o_rw      = w_d;
    o_alu_op  = i_ir[15:12];
    o_imm     = i_ir[IMM_W-1:0];
    o_is_mem  = 1'b0;
    o_is_st   = 1'b0;
    o_is_wb   = 1'b0;
    o_is_link = 1'b0;
    o_pinc    = 1'b0;
    unique case (1'b1)
      w_op == OP_ALU: o_is_wb = 1'b1;
      w_op == OP_LD: begin
        o_is_mem = 1'b1;
        o_is_wb  = 1'b1;
      end
      w_op == OP_ST: begin
        o_is_mem = 1'b1;
        o_is_st  = 1'b1;
      end
      w_op == OP_CALL: begin
        o_is_link = 1'b1;
        o_rw      = R_PC;
      end
      default: ;
    endcase
`ifdef CPU2_SEQ_POSTINC_EN
    // a load into the base register wins over the base update
    o_pinc = o_is_mem & i_ir[PINC_B]
           & ~(o_is_wb & (w_d == w_a));
`else
    o_pinc = 1'b0;
`endif
  end

endmodule

// File: rtl/cpu2_seq.sv
// cpu2 multi-cycle fetch/execute sequencer: FSM and memory handshake.
// Optional feature macro: CPU2_SEQ_POSTINC_EN (load/store post-increment).
module cpu2_seq
  import cpu2_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] da,
  input  logic [WIDTH-1:0] dd,
  input  logic [WIDTH-1:0] alu_res,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       ra,
  output logic [3:0]       rb,
  output logic [3:0]       rd,
  output logic [3:0]       rw,
  output logic [3:0]       rt,
  output logic             fn_inc_pc,
  output logic             fn_link,
  output logic             fn_wb,
  output logic             fn_ra_change,
  output logic [WIDTH-1:0] wb_data,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] ir,
  output logic             halted
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_ir;
  logic             r_run;
  logic [IMM_W-1:0] w_imm;
  logic             w_is_mem;
  logic             w_is_st;
  logic             w_is_wb;
  logic             w_is_link;
  logic             w_pinc;
  logic [WIDTH-1:0] w_sext;
  logic [WIDTH-1:0] w_zext;
  logic [WIDTH-1:0] w_ea;
  logic             w_fetch_ack;

  cpu2_seq_dec u_dec (
    .i_ir      (r_ir[31:0]),
    .o_ra      (ra),
    .o_rb      (rb),
    .o_rd      (rd),
    .o_rw      (rw),
    .o_rt      (rt),
    .o_alu_op  (alu_op),
    .o_imm     (w_imm),
    .o_is_mem  (w_is_mem),
    .o_is_st   (w_is_st),
    .o_is_wb   (w_is_wb),
    .o_is_link (w_is_link),
    .o_pinc    (w_pinc)
  );

  assign w_sext = {{(WIDTH-IMM_W){w_imm[IMM_W-1]}}, w_imm};
  assign w_zext = {{(WIDTH-IMM_W){1'b0}}, w_imm};
  assign w_ea   = da + w_sext;
  assign ir     = r_ir;

  // r_run keeps the first fetch one cycle behind reset release
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
      if (w_fetch_ack)
        r_ir <= mem_rdata;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_fetch_ack  = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fn_inc_pc    = 1'b0;
    fn_link      = 1'b0;
    fn_wb        = 1'b0;
    fn_ra_change = 1'b0;
    wb_data      = '0;
    halted       = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        if (r_run) begin
          mem_req  = 1'b1;
          mem_addr = pc;
          if (mem_ack) begin
            w_fetch_ack = 1'b1;
            fn_inc_pc   = 1'b1;
            w_next = fetch_next(
              mem_rdata[OP_HI:OP_LO]);
          end
        end
      end
      S_EXEC: begin
        w_next = S_FETCH;
        if (w_is_link) begin
          fn_link = 1'b1;
          fn_wb   = 1'b1;
          wb_data = w_zext;
        end else if (w_is_wb) begin
          fn_wb   = 1'b1;
          wb_data = alu_res;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = w_is_st;
        mem_addr  = w_ea;
        mem_wdata = dd;
        if (mem_ack) begin
          w_next       = S_FETCH;
          fn_ra_change = w_pinc;
          if (w_is_wb) begin
            fn_wb   = 1'b1;
            wb_data = mem_rdata;
          end
        end
      end
      S_HALT: halted = 1'b1;
    endcase
  end

  logic w_unused;
  assign w_unused = w_is_mem;

endmodule

// File: tb/tb_cpu2_seq.sv
// Self-checking bench for cpu2_seq: vector table, random model, corner sequences.
// Follows CPU2_SEQ_POSTINC_EN for post-increment expectations.
module tb_cpu2_seq;

`ifdef CPU2_SEQ_POSTINC_EN
  localparam bit PINC = 1'b1;
`else
  localparam bit PINC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, da, dd, alu_res, mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  ra, rb, rd, rw, rt;
  logic        fn_inc_pc, fn_link, fn_wb, fn_ra_change;
  logic [31:0] wb_data;
  logic [3:0]  alu_op;
  logic [31:0] ir;
  logic        halted;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu2_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .pc(pc), .da(da), .dd(dd),
    .alu_res(alu_res), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ra(ra), .rb(rb), .rd(rd), .rw(rw), .rt(rt),
    .fn_inc_pc(fn_inc_pc), .fn_link(fn_link),
    .fn_wb(fn_wb), .fn_ra_change(fn_ra_change),
    .wb_data(wb_data), .alu_op(alu_op), .ir(ir),
    .halted(halted)
  );

  typedef struct {
    logic [31:0] instr, pc, da, dd, alu, rdata;
    int          fw, mw;
    logic        we;
    logic [31:0] addr;
    logic        wb;
    logic [3:0]  rw;
    logic [31:0] wbd;
    logic        link, rac;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_run++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] instr, p, a, d, alu, rdat,
    input int fw, mw,
    input logic we, input logic [31:0] addr,
    input logic wb, input logic [3:0] rwv,
    input logic [31:0] wbd,
    input logic link, rac);
    vec_t v;
    v.instr = instr; v.pc = p; v.da = a; v.dd = d;
    v.alu = alu; v.rdata = rdat; v.fw = fw; v.mw = mw;
    v.we = we; v.addr = addr; v.wb = wb; v.rw = rwv;
    v.wbd = wbd; v.link = link; v.rac = rac;
    return v;
  endfunction

  // Expected behaviour per instruction from the ISA rules
  function automatic vec_t model(
    input logic [31:0] instr, p, a, d, alu, rdat,
    input int fw, mw);
    vec_t v;
    logic [3:0]  op, fd, fa;
    logic [31:0] sx;
    op = instr[31:28];
    fd = instr[27:24];
    fa = instr[23:20];
    sx = {{16{instr[15]}}, instr[15:0]};
    v = mk(instr, p, a, d, alu, rdat, fw, mw,
           0, 0, 0, 0, 0, 0, 0);
    v.we   = (op == 4'h2);
    v.addr = a + sx;
    v.wb   = (op == 4'h0) || (op == 4'h1) || (op == 4'h3);
    v.link = (op == 4'h3);
    v.rw   = (op == 4'h3) ? 4'hF : fd;
    if (op == 4'h0)      v.wbd = alu;
    else if (op == 4'h1) v.wbd = rdat;
    else                 v.wbd = {16'h0, instr[15:0]};
    v.rac = PINC && (op == 4'h1 || op == 4'h2)
         && instr[16] && !(op == 4'h1 && fd == fa);
    return v;
  endfunction

  task automatic do_fetch(input logic [31:0] instr,
                          input logic [31:0] p,
                          input int fw, input string t);
    logic [31:0] junk;
    for (int w = 0; w <= fw; w++) begin
      @(negedge clk);
      junk      = $urandom;
      pc        = p;
      mem_ack   = (w == fw);
      mem_rdata = (w == fw) ? instr : junk;
      da        = $urandom;
      alu_res   = $urandom;
      #1;
      chk({t, ".f_req"}, mem_req, 1);
      chk({t, ".f_we"}, mem_we, 0);
      chk({t, ".f_addr"}, mem_addr, p);
      chk({t, ".f_inc"}, fn_inc_pc, (w == fw));
      chk({t, ".f_wb"}, fn_wb, 0);
    end
  endtask

  task automatic do_instr(input vec_t v, input string t);
    logic [3:0]  op;
    logic        ack;
    logic [31:0] junk;
    op = v.instr[31:28];
    do_fetch(v.instr, v.pc, v.fw, t);
    if (op == 4'h1 || op == 4'h2) begin
      for (int w = 0; w <= v.mw; w++) begin
        @(negedge clk);
        junk      = $urandom;
        ack       = (w == v.mw);
        mem_ack   = ack;
        mem_rdata = ack ? v.rdata : junk;
        da        = v.da;
        dd        = v.dd;
        #1;
        chk({t, ".ir"}, ir, v.instr);
        chk({t, ".m_req"}, mem_req, 1);
        chk({t, ".m_we"}, mem_we, v.we);
        chk({t, ".m_addr"}, mem_addr, v.addr);
        chk({t, ".m_wdata"}, mem_wdata, v.dd);
        chk({t, ".m_inc"}, fn_inc_pc, 0);
        chk({t, ".m_rw"}, rw, v.rw);
        chk({t, ".m_wb"}, fn_wb, ack && v.wb);
        chk({t, ".m_rac"}, fn_ra_change, ack && v.rac);
        if (ack && v.wb)
          chk({t, ".m_wbd"}, wb_data, v.wbd);
      end
    end else begin
      @(negedge clk);
      mem_ack = 1'($urandom_range(0, 1));
      alu_res = v.alu;
      da      = v.da;
      #1;
      chk({t, ".ir"}, ir, v.instr);
      chk({t, ".x_req"}, mem_req, 0);
      chk({t, ".x_inc"}, fn_inc_pc, 0);
      chk({t, ".x_wb"}, fn_wb, v.wb);
      chk({t, ".x_link"}, fn_link, v.link);
      chk({t, ".x_rw"}, rw, v.rw);
      chk({t, ".x_op"}, alu_op, v.instr[15:12]);
      chk({t, ".x_rac"}, fn_ra_change, 0);
      if (v.wb)
        chk({t, ".x_wbd"}, wb_data, v.wbd);
    end
  endtask

  initial begin
    vec_t        v;
    logic [31:0] r;
    logic [3:0]  op;

    tbl[0] = mk(32'h0312_3000, 0, 0, 0, 32'hDEAD_BEEF, 0,
                0, 0, 0, 0, 1, 3, 32'hDEAD_BEEF, 0, 0);
    tbl[1] = mk(32'h1520_FFFF, 4, 32'h100, 0, 0,
                32'h1234_5678, 0, 3, 0, 32'hFF, 1, 5,
                32'h1234_5678, 0, 0);
    tbl[2] = mk(32'h2241_0004, 8, 32'h2000, 32'hCAFE_F00D,
                0, 0, 1, 0, 1, 32'h2004, 0, 2, 0, 0, PINC);
    tbl[3] = mk(32'h3000_0040, 7, 0, 0, 32'h1111, 0,
                0, 0, 0, 0, 1, 15, 32'h40, 1, 0);
    tbl[4] = mk(32'h5123_4567, 32'h40, 0, 0, 32'h2222, 0,
                0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[5] = mk(32'h1331_0010, 9, 32'hFFFF_FFF8, 0, 0,
                32'hA5A5_5A5A, 0, 1, 0, 32'h8, 1, 3,
                32'hA5A5_5A5A, 0, 0);
    tbl[6] = mk(32'h1741_8000, 10, 32'h0001_0000, 0, 0,
                32'h77, 0, 0, 0, 32'h8000, 1, 7, 32'h77,
                0, PINC);
    tbl[7] = mk(32'h2900_7FFF, 11, 32'h1, 32'h55, 0, 0,
                2, 2, 1, 32'h8000, 0, 9, 0, 0, 0);

    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0312_3000;
    pc = 0; da = 0; dd = 0; alu_res = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst.req", mem_req, 0);
    chk("rst.halted", halted, 0);
    chk("rst.ir", ir, 0);
    chk("rst.wbd", wb_data, 0);
    chk("rst.fn", {fn_inc_pc, fn_link, fn_wb, fn_ra_change}, 0);
    reset = 1'b1; mem_ack = 1'b0;
    @(posedge clk);

    for (int i = 0; i < 8; i++)
      do_instr(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 14));
      r  = $urandom;
      v  = model({op, r[27:0]}, $urandom, $urandom,
                 $urandom, $urandom, $urandom,
                 $urandom_range(0, 2), $urandom_range(0, 3));
      do_instr(v, $sformatf("rnd%0d", i));
    end

    do_fetch(32'h1520_FFFF, 32'h20, 0, "midrst");
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      mem_ack = 1'b0; da = 32'h100;
      #1;
      chk("midrst.req", mem_req, 1);
      chk("midrst.addr", mem_addr, 32'hFF);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst.drop", mem_req, 0);
    chk("midrst.wb", fn_wb, 0);
    chk("midrst.ir", ir, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    do_instr(tbl[0], "after_rst");

    do_fetch(32'hF000_0000, 32'h30, 1, "halt");
    for (int w = 0; w < 5; w++) begin
      @(negedge clk);
      mem_ack = 1'b1;
      #1;
      chk("halt.h", halted, 1);
      chk("halt.req", mem_req, 0);
      chk("halt.fn", {fn_inc_pc, fn_link, fn_wb, fn_ra_change}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
